// File: rtl/mp_add_seq.sv
// Multi-precision sequential adder: computes a+b+cin over NSLICE 32-bit
// slices, one slice per cycle starting from the LSB slice, with the carry
// held in a register between slices.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE (and never while rst_n is low).
// out_valid stays high with out_sum/out_cout frozen until out_ready is seen.
module mp_add_seq #(
  parameter  int NSLICE = 4,
  localparam int W      = 32 * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          valid_q, valid_d;

  logic [31:0]   slice_a;
  logic [31:0]   slice_b;
  logic [31:0]   slice_sum;
  logic          slice_cout;

  // Select the operand slice currently being added.
  always_comb begin
    slice_a = a_q[32*idx_q +: 32];
    slice_b = b_q[32*idx_q +: 32];
  end

  // 32-bit ripple-carry slice adder fed by the chained carry register.
  always_comb begin
    logic c;
    slice_sum = '0;
    c         = carry_q;
    for (int i = 0; i < 32; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
      c            = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
    end
    slice_cout = c;
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[32*idx_q +: 32] = slice_sum;
        carry_d               = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        // A same-cycle in_valid is deliberately not taken here; it is
        // accepted on the next cycle once back in IDLE.
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset discards any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE) & rst_n;
  assign out_valid   = valid_q;
  assign out_sum     = sum_q;
  assign out_cout    = cout_q;
  assign busy        = (state_q == RUN) | (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed testbench for mp_add_seq: a 4-slice instance for the main
// scenarios and a 1-slice instance for the single-slice build.
module tb_mp_add_seq;

  localparam int NS = 4;
  localparam int W  = 32 * NS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-slice DUT signals
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, busy;
  logic [W-1:0] out_sum;
  logic [1:0]   dbg_state;

  // 1-slice DUT signals
  logic         in_valid1, in_ready1, in_cin1;
  logic [31:0]  in_a1, in_b1;
  logic         out_valid1, out_ready1, out_cout1, busy1;
  logic [31:0]  out_sum1;
  logic [1:0]   dbg_state1;

  mp_add_seq #(.NSLICE(NS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  mp_add_seq #(.NSLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1),
    .busy(busy1), .dbg_state_o(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         expc_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  // Present an operand at a negedge, hold until accepted, then scramble the
  // inputs so the DUT must have registered them. Returns at the negedge
  // following the acceptance edge.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
  endtask

  // Count negedges until out_valid, starting at the negedge after acceptance.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%b expected 1", out_valid);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_a = '1; in_b = '1; in_cin = 1'b1; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_carry_full();
    int lat;
    send_op({W{1'b1}}, '0, 1'b1);
    wait_result(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL full_latency: got %0d expected 4", lat); end
    n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL full_sum: got %h expected 0", out_sum); end
    n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL full_cout: got %b expected 1", out_cout); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
    take_result();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_carry_cross();
    int lat;
    send_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
    wait_result(lat);
    n_checks++;
    if (out_sum !== 128'h0000_0000_0000_0001_0000_0000_0000_0000) begin
      n_fail++; $display("FAIL cross_sum: got %h expected 00000000000000010000000000000000", out_sum);
    end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL cross_cout: got %b expected 0", out_cout); end
    take_result();
  endtask

  task automatic test_stall();
    int lat;
    logic [W-1:0] e1, e2;
    e1 = 128'h0000_0011_0000_0022_0000_0033_0000_0045;
    e2 = 128'h0;
    send_op(128'h0000_0001_0000_0002_0000_0003_0000_0004,
            128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b1);
    wait_result(lat);
    // Offer the next operand the whole time the result is held.
    in_valid = 1'b1;
    in_a = 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000;
    in_b = 128'h0000_0001_0000_0000_0000_0000_0000_0000;
    in_cin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_checks++; if (out_sum !== e1) begin n_fail++; $display("FAIL stall_sum[%0d]: got %h expected %h", i, out_sum, e1); end
      n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL stall_cout[%0d]: got %b expected 0", i, out_cout); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // Handshake edge must not have taken the pending operand.
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_no_overlap_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = '0; in_b = '0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_next_accept: busy=%b expected 1", busy); end
    wait_result(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL stall_next_latency: got %0d expected 4", lat); end
    n_checks++; if (out_sum !== e2) begin n_fail++; $display("FAIL stall_next_sum: got %h expected %h", out_sum, e2); end
    n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL stall_next_cout: got %b expected 1", out_cout); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    send_op({W{1'b1}}, {W{1'b1}}, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready_low: got %b expected 0", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready_high: got %b expected 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_pulse: out_valid seen=1 expected 0"); end
    send_op(128'h0000_0003_0000_0000_0000_0000_0000_0000,
            128'h0000_0004_0000_0000_0000_0000_0000_0000, 1'b1);
    wait_result(lat);
    n_checks++;
    if (out_sum !== 128'h0000_0007_0000_0000_0000_0000_0000_0001) begin
      n_fail++; $display("FAIL midrst_next_sum: got %h expected 00000007000000000000000000000001", out_sum);
    end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_next_cout: got %b expected 0", out_cout); end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va[4], vb[4], ve[4];
    logic         vc[4], vo[4];
    logic [W-1:0] e;
    logic         ec;
    int k, last_acc, n_got;
    bit acc_prev;
    va[0] = {1'b1, {(W-1){1'b0}}}; vb[0] = {1'b1, {(W-1){1'b0}}}; vc[0] = 1'b0;
    ve[0] = '0;                     vo[0] = 1'b1;
    va[1] = {W{1'b1}};              vb[1] = {W{1'b1}};              vc[1] = 1'b1;
    ve[1] = {W{1'b1}};              vo[1] = 1'b1;
    va[2] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vb[2] = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;       vc[2] = 1'b0;
    ve[2] = {W{1'b1}};              vo[2] = 1'b0;
    va[3] = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
    vb[3] = 128'h1;                                             vc[3] = 1'b1;
    ve[3] = 128'h0000_0000_FFFF_FFFF_0000_0001_0000_0001;       vo[3] = 1'b0;
    k = 0; last_acc = -1; n_got = 0; acc_prev = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_cin = vc[0];
    for (int c = 0; c < 80 && n_got < 4; c++) begin
      if (acc_prev) begin
        k++;
        if (k < 4) begin
          in_a = va[k]; in_b = vb[k]; in_cin = vc[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) begin
        exp_q.push_back(ve[k]);
        expc_q.push_back(vo[k]);
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != NS + 2) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, cyc - last_acc, NS + 2);
          end
        end
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got %h expected none", out_sum);
        end else begin
          e  = exp_q.pop_front();
          ec = expc_q.pop_front();
          if (out_sum !== e || out_cout !== ec) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got %b_%h expected %b_%h", n_got, out_cout, out_sum, ec, e);
          end
        end
        n_got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (n_got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", n_got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_nslice1();
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 32'hFFFF_FFFF; in_b1 = 32'h1; in_cin1 = 1'b1;
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL ns1_ready: got %b expected 1", in_ready1); end
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0;
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL ns1_early_valid: got %b expected 0", out_valid1); end
    @(negedge clk);
    n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL ns1_latency: out_valid=%b expected 1", out_valid1); end
    n_checks++; if (out_sum1 !== 32'h0000_0001) begin n_fail++; $display("FAIL ns1_sum: got %h expected 00000001", out_sum1); end
    n_checks++; if (out_cout1 !== 1'b1) begin n_fail++; $display("FAIL ns1_cout: got %b expected 1", out_cout1); end
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL ns1_drop_valid: got %b expected 0", out_valid1); end
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL ns1_idle_ready: got %b expected 1", in_ready1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_carry_full();
    test_carry_cross();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_nslice1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
